// File: rtl/elevator_dispatch.sv
// Elevator car controller: call latching, SCAN direction, travel/door timing.
// Define ESTOP_EN to add the estop input and the HALT state.
module elevator_dispatch #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 100_000_000,
  parameter int DOOR_CYCLES   = 200_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [2:0]            floor,
`ifdef ESTOP_EN
  input  logic                  estop,
`endif
  output logic                  mux_sig,
  output logic                  floor_load,
  output logic                  door_open,
  output logic                  moving,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ?
                        TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    ARRIVE,
    DOOR
`ifdef ESTOP_EN
    , HALT
`endif
  } state_t;

  state_t                  state, state_d;
  logic [TW-1:0]           timer, timer_d;
  logic [NUM_FLOORS-1:0]   pending_d;
  logic                    mux_d;

  logic [NUM_FLOORS-1:0]   fl_mask;
  logic                    above, below, here, call_here;
  logic                    at_top, at_bot;
  logic                    ahead, behind, at_limit;

  always_comb begin
    above   = 1'b0;
    below   = 1'b0;
    fl_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor)) above = above | pending[i];
      if (i < int'(floor)) below = below | pending[i];
      if (i == int'(floor)) fl_mask[i] = 1'b1;
    end
    here      = |(pending & fl_mask);
    call_here = |(call_btn & fl_mask);
  end

  assign at_top   = int'(floor) >= NUM_FLOORS - 1;
  assign at_bot   = floor == 3'd0;
  assign ahead    = mux_sig ? above : below;
  assign behind   = mux_sig ? below : above;
  assign at_limit = mux_sig ? at_top : at_bot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      pending <= '0;
      mux_sig <= 1'b1;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      pending <= pending_d;
      mux_sig <= mux_d;
    end
  end

  always_comb begin
    state_d    = state;
    timer_d    = '0;
    pending_d  = pending | call_btn;
    mux_d      = mux_sig;
    floor_load = 1'b0;
    door_open  = 1'b0;
    moving     = 1'b0;
    unique case (state)
      IDLE: begin
        if (here) begin
          state_d   = DOOR;
          pending_d = pending_d & ~fl_mask;
        end else if (above && (mux_sig || !below)) begin
          mux_d   = 1'b1;
          state_d = MOVE;
        end else if (below) begin
          mux_d   = 1'b0;
          state_d = MOVE;
        end
      end
      MOVE: begin
        moving = 1'b1;
        if (timer == TRAVEL_LAST) begin
          // never step past the end floors, even on a stray direction
          if (at_limit) begin
            state_d = IDLE;
          end else begin
            floor_load = 1'b1;
            state_d    = ARRIVE;
          end
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      ARRIVE: begin
        moving = 1'b1;
        if (here) begin
          state_d   = DOOR;
          pending_d = pending_d & ~fl_mask;
        end else if (ahead) begin
          state_d = MOVE;
        end else if (behind) begin
          mux_d   = ~mux_sig;
          state_d = MOVE;
        end else begin
          state_d = IDLE;
        end
      end
      DOOR: begin
        door_open = 1'b1;
        pending_d = pending_d & ~fl_mask;
        if (call_here) begin
          timer_d = '0;
        end else if (timer == DOOR_LAST) begin
          state_d = IDLE;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
`ifdef ESTOP_EN
      HALT: begin
        door_open = 1'b1;
        pending_d = '0;
        timer_d   = timer;
        state_d   = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef ESTOP_EN
    // stop wins over everything, including a due floor strobe
    if (estop) begin
      state_d    = HALT;
      floor_load = 1'b0;
      pending_d  = '0;
      timer_d    = timer;
    end
`endif
  end

endmodule

// File: tb/tb_elevator_dispatch.sv
// Scoreboard bench for elevator_dispatch with a bench-side floor register.
// Define ESTOP_EN to also exercise the emergency stop.
module tb_elevator_dispatch;
  localparam int NF = 8;
  localparam int TC = 4;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] call_btn;
  logic [2:0]    floor;
  logic          mux_sig, floor_load, door_open, moving;
  logic [NF-1:0] pending;
`ifdef ESTOP_EN
  logic          estop;
`endif

  logic [2:0]    set_val;
  logic          set_en;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [31:0]   sb[$];
  int            load_cyc[$];
  int            open_cyc = 0;
  int            dlen = 0;
  logic          dprev = 1'b0;
  logic          mon_en = 1'b0;
  int            c;

  elevator_dispatch #(
    .NUM_FLOORS(NF),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .call_btn(call_btn),
    .floor(floor),
`ifdef ESTOP_EN
    .estop(estop),
`endif
    .mux_sig(mux_sig),
    .floor_load(floor_load),
    .door_open(door_open),
    .moving(moving),
    .pending(pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // external floor register fed by the next-floor adder
  always @(posedge clk) begin
    if (set_en) floor <= set_val;
    else if (floor_load) floor <= mux_sig ? floor + 3'd1 : floor - 3'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // kind 1 = load {dir, from floor}, 2 = door opens at floor, 3 = door length
  function automatic logic [31:0] ev(input int kind, input logic d,
                                     input int v);
    return {8'(kind), 7'd0, d, 16'(v)};
  endfunction

  task automatic score(input logic [31:0] e);
    if (sb.size() == 0) chk("unexpected_event", e, 32'hffff_ffff);
    else chk("event", e, sb.pop_front());
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (floor_load) begin
        load_cyc.push_back(cyc);
        score(ev(1, mux_sig, int'(floor)));
      end
      if (door_open) begin
        if (!dprev) begin
          open_cyc = cyc;
          score(ev(2, 1'b0, int'(floor)));
        end
        dlen++;
      end else if (dprev) begin
        score(ev(3, 1'b0, dlen));
        dlen = 0;
      end
      dprev = door_open;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NF-1:0] m, output int at);
    call_btn = m;
    at = cyc;
    tick();
    call_btn = '0;
  endtask

  task automatic set_floor(input logic [2:0] v);
    set_val = v;
    set_en  = 1'b1;
    tick();
    set_en  = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    chk("drain_left", sb.size(), 0);
    repeat (2) tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pend"}, pending, 0);
    chk({tag, "_mov"}, moving, 0);
    chk({tag, "_door"}, door_open, 0);
  endtask

  initial begin
    reset    = 1'b1;
    call_btn = '0;
    set_en   = 1'b1;
    set_val  = 3'd0;
`ifdef ESTOP_EN
    estop    = 1'b0;
`endif
    repeat (3) tick();
    set_en = 1'b0;
    chk("rst_dir", mux_sig, 1);
    chk("rst_load", floor_load, 0);
    chk_idle("rst");
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // floor 0 -> 2
    sb.push_back(ev(1, 1'b1, 0));
    sb.push_back(ev(1, 1'b1, 1));
    sb.push_back(ev(2, 1'b0, 2));
    sb.push_back(ev(3, 1'b0, DC));
    pulse(8'h04, c);
    drain(80);
    chk("t1_nload", load_cyc.size(), 2);
    chk("t1_lat", load_cyc.size() > 0 ? load_cyc[0] - c : -1, 1 + TC);
    chk("t1_gap", load_cyc.size() > 1 ? load_cyc[1] - load_cyc[0] : -1,
        1 + TC);
    chk("t1_open", load_cyc.size() > 1 ? open_cyc - load_cyc[1] : -1, 2);
    chk("t1_floor", floor, 2);
    chk_idle("t1");
    load_cyc.delete();

    // from 3: serve 5 going up, then reverse to 1
    set_floor(3'd3);
    chk("t2_dir0", mux_sig, 1);
    sb.push_back(ev(1, 1'b1, 3));
    sb.push_back(ev(1, 1'b1, 4));
    sb.push_back(ev(2, 1'b0, 5));
    sb.push_back(ev(3, 1'b0, DC));
    for (int f = 5; f >= 2; f--) sb.push_back(ev(1, 1'b0, f));
    sb.push_back(ev(2, 1'b0, 1));
    sb.push_back(ev(3, 1'b0, DC));
    pulse(8'h22, c);
    drain(200);
    chk("t2_lat", load_cyc.size() > 0 ? load_cyc[0] - c : -1, 1 + TC);
    chk("t2_dir", mux_sig, 0);
    chk("t2_floor", floor, 1);
    chk_idle("t2");
    load_cyc.delete();

    // top floor with up direction: door only, no strobe
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_floor(3'd7);
    chk("t3_dir0", mux_sig, 1);
    sb.push_back(ev(2, 1'b0, 7));
    sb.push_back(ev(3, 1'b0, DC));
    pulse(8'h80, c);
    drain(40);
    repeat (6) tick();
    chk("t3_open", open_cyc - c, 2);
    chk("t3_nload", load_cyc.size(), 0);
    chk("t3_floor", floor, 7);
    chk_idle("t3");

    // re-press during door restarts the door timer
    set_floor(3'd4);
    sb.push_back(ev(2, 1'b0, 4));
    sb.push_back(ev(3, 1'b0, DC + 2));
    pulse(8'h10, c);
    tick();
    chk("t4_door_a", door_open, 1);
    tick();
    call_btn = 8'h10;
    tick();
    call_btn = '0;
    chk("t4_door_b", door_open, 1);
    chk("t4_pend", pending, 0);
    drain(40);
    chk_idle("t4");

    // reset during a downward move at timer 2
    pulse(8'h02, c);
    tick();
    chk("t5_mov", moving, 1);
    chk("t5_dir", mux_sig, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("t5_load", floor_load, 0);
    chk("t5_rdir", mux_sig, 1);
    chk_idle("t5");
    reset = 1'b0;
    repeat (8) tick();
    chk("t5_floor", floor, 4);
    chk("t5_nload", load_cyc.size(), 0);
    chk_idle("t5_post");

`ifdef ESTOP_EN
    // estop on the strobe cycle
    set_floor(3'd0);
    sb.push_back(ev(2, 1'b0, 0));
    sb.push_back(ev(3, 1'b0, 1));
    pulse(8'h02, c);
    repeat (TC) tick();
    estop = 1'b1;
    #1;
    chk("t6_load", floor_load, 0);
    tick();
    estop = 1'b0;
    chk("t6_door", door_open, 1);
    chk("t6_mov", moving, 0);
    chk("t6_pend", pending, 0);
    tick();
    chk_idle("t6");
    drain(20);
    chk("t6_floor", floor, 0);
    chk("t6_nload", load_cyc.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
